// File: rtl/airlock_transit_ctrl.sv
// Two-door airlock sequencer: arbitrates Arrive/Depart transits, drives doors and pump, keeps doors interlocked.
// Optional macro DOOR_TIMEOUT_EN: an open door auto-closes after DOOR_TIMEOUT cycles.
module airlock_transit_ctrl #(
    parameter int PRESS_CYCLES = 8,
    parameter int EVAC_CYCLES  = 10,
    parameter int DOOR_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic arriveReq_i,
    input  logic departReq_i,
    input  logic doorClose_i,
    output logic outerDoor_o,
    output logic innerDoor_o,
    output logic pumpIn_o,
    output logic pumpOut_o,
    output logic arriveAck_o,
    output logic departAck_o,
    output logic busy_o,
    output logic pressurized_o
);

    localparam int MAXA = (PRESS_CYCLES > EVAC_CYCLES) ? PRESS_CYCLES : EVAC_CYCLES;
    localparam int MAXC = (MAXA > DOOR_TIMEOUT) ? MAXA : DOOR_TIMEOUT;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] EVAC_LOAD  = TW'(EVAC_CYCLES - 1);

    typedef enum logic [2:0] {
        RECOVER, P_IDLE, E_IDLE, EVAC, PRESS, OUTER_OPEN, INNER_OPEN
    } state_e;

    typedef enum logic {
        DIR_ARR = 1'b0,
        DIR_DEP = 1'b1
    } dir_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    dir_e          dir_q, dir_d;
    dir_e          lastGrant_q, lastGrant_d;
    logic          hold_q;
    logic          idle;
    logic          grantArr;
    logic          grantDep;
    logic          timerZero;
    logic          closeReq;

    assign idle      = (state_q == P_IDLE) || (state_q == E_IDLE);
    assign timerZero = (timer_q == '0);
    // Round-robin on contention: the side not granted last time wins.
    assign grantArr  = idle && !hold_q && arriveReq_i && (!departReq_i || lastGrant_q == DIR_DEP);
    assign grantDep  = idle && !hold_q && departReq_i && (!arriveReq_i || lastGrant_q == DIR_ARR);

`ifdef DOOR_TIMEOUT_EN
    logic [TW-1:0] doorCnt_q, doorCnt_d;
    logic          doorOpen;

    assign doorOpen = (state_q == OUTER_OPEN) || (state_q == INNER_OPEN);
    assign closeReq = doorClose_i || (doorOpen && doorCnt_q == '0);

    always_comb begin
        doorCnt_d = doorCnt_q;
        if ((state_d == OUTER_OPEN || state_d == INNER_OPEN) && state_d != state_q) begin
            doorCnt_d = TW'(DOOR_TIMEOUT - 1);
        end else if (doorOpen && doorCnt_q != '0) begin
            doorCnt_d = doorCnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            doorCnt_q <= TW'(DOOR_TIMEOUT - 1);
        end else begin
            doorCnt_q <= doorCnt_d;
        end
    end
`else
    assign closeReq = doorClose_i;
`endif

    // hold_q marks the cycle right after reset: everything quiet, recovery not yet counting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RECOVER;
            timer_q     <= PRESS_LOAD;
            dir_q       <= DIR_ARR;
            lastGrant_q <= DIR_DEP;
            hold_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dir_q       <= dir_d;
            lastGrant_q <= lastGrant_d;
            hold_q      <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        dir_d       = dir_q;
        lastGrant_d = lastGrant_q;
        if (!hold_q) begin
            case (state_q)
                RECOVER: begin
                    if (timerZero) state_d = P_IDLE;
                    else           timer_d = timer_q - 1'b1;
                end
                P_IDLE: begin
                    if (grantArr) begin
                        dir_d       = DIR_ARR;
                        lastGrant_d = DIR_ARR;
                        state_d     = EVAC;
                        timer_d     = EVAC_LOAD;
                    end else if (grantDep) begin
                        dir_d       = DIR_DEP;
                        lastGrant_d = DIR_DEP;
                        state_d     = INNER_OPEN;
                    end
                end
                E_IDLE: begin
                    if (grantArr) begin
                        dir_d       = DIR_ARR;
                        lastGrant_d = DIR_ARR;
                        state_d     = OUTER_OPEN;
                    end else if (grantDep) begin
                        dir_d       = DIR_DEP;
                        lastGrant_d = DIR_DEP;
                        state_d     = PRESS;
                        timer_d     = PRESS_LOAD;
                    end
                end
                EVAC: begin
                    if (timerZero) state_d = OUTER_OPEN;
                    else           timer_d = timer_q - 1'b1;
                end
                PRESS: begin
                    if (timerZero) state_d = INNER_OPEN;
                    else           timer_d = timer_q - 1'b1;
                end
                OUTER_OPEN: begin
                    if (closeReq) begin
                        if (dir_q == DIR_ARR) begin
                            state_d = PRESS;
                            timer_d = PRESS_LOAD;
                        end else begin
                            state_d = E_IDLE;
                        end
                    end
                end
                INNER_OPEN: begin
                    if (closeReq) begin
                        if (dir_q == DIR_ARR) begin
                            state_d = P_IDLE;
                        end else begin
                            state_d = EVAC;
                            timer_d = EVAC_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = RECOVER;
                    timer_d = PRESS_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        outerDoor_o   = 1'b0;
        innerDoor_o   = 1'b0;
        pumpIn_o      = 1'b0;
        pumpOut_o     = 1'b0;
        arriveAck_o   = grantArr;
        departAck_o   = grantDep;
        busy_o        = 1'b0;
        pressurized_o = 1'b0;
        if (!hold_q) begin
            case (state_q)
                RECOVER: begin
                    pumpIn_o      = 1'b1;
                    pressurized_o = timerZero;
                end
                P_IDLE: begin
                    pressurized_o = 1'b1;
                end
                EVAC: begin
                    pumpOut_o = 1'b1;
                    busy_o    = 1'b1;
                end
                PRESS: begin
                    pumpIn_o      = 1'b1;
                    busy_o        = 1'b1;
                    pressurized_o = timerZero;
                end
                OUTER_OPEN: begin
                    outerDoor_o = 1'b1;
                    busy_o      = 1'b1;
                end
                INNER_OPEN: begin
                    innerDoor_o   = 1'b1;
                    busy_o        = 1'b1;
                    pressurized_o = 1'b1;
                end
                default: begin
                    busy_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_airlock_transit_ctrl.sv
// Scoreboard bench for airlock_transit_ctrl: stimulus pushes per-cycle expected outputs derived from
// transit-level rules; a negedge monitor pops and compares. Honours DOOR_TIMEOUT_EN when defined.
module tb_airlock_transit_ctrl;

    localparam int PRESS_N = 8;
    localparam int EVAC_N  = 10;
    localparam int DOOR_N  = 16;

    localparam logic [7:0] E_OUTER = 8'h80;
    localparam logic [7:0] E_INNER = 8'h40;
    localparam logic [7:0] E_PIN   = 8'h20;
    localparam logic [7:0] E_POUT  = 8'h10;
    localparam logic [7:0] E_AACK  = 8'h08;
    localparam logic [7:0] E_DACK  = 8'h04;
    localparam logic [7:0] E_BUSY  = 8'h02;
    localparam logic [7:0] E_PRESS = 8'h01;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arriveReq = 1'b0;
    logic departReq = 1'b0;
    logic doorClose = 1'b0;
    logic outerDoor, innerDoor, pumpIn, pumpOut, arriveAck, departAck, busy, pressurized;

    airlock_transit_ctrl #(
        .PRESS_CYCLES(PRESS_N),
        .EVAC_CYCLES (EVAC_N),
        .DOOR_TIMEOUT(DOOR_N)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .arriveReq_i  (arriveReq),
        .departReq_i  (departReq),
        .doorClose_i  (doorClose),
        .outerDoor_o  (outerDoor),
        .innerDoor_o  (innerDoor),
        .pumpIn_o     (pumpIn),
        .pumpOut_o    (pumpOut),
        .arriveAck_o  (arriveAck),
        .departAck_o  (departAck),
        .busy_o       (busy),
        .pressurized_o(pressurized)
    );

    always #5 clk = ~clk;

    logic [7:0] expQ[$];
    bit         careQ[$];
    string      tagQ[$];
    int         compared = 0;
    int         mismatched = 0;

    // Chamber pressure side and arbitration history, the only state the model needs.
    bit interior = 1'b0;
    bit lastArr = 1'b0;
    bit aborted = 1'b0;
    bit resetPending = 1'b0;

    function automatic bit rndBit(input int oneIn);
        return ($urandom % oneIn) == 0;
    endfunction

    function automatic logic [7:0] idleVec();
        return interior ? E_PRESS : 8'h00;
    endfunction

    task automatic checkOutput(input logic [7:0] got);
        logic [7:0] e;
        bit         c;
        string      t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            c = careQ.pop_front();
            t = tagQ.pop_front();
            if (c) begin
                compared++;
                if (got !== e) begin
                    mismatched++;
                    $display("[TB] FAIL %s @%0t: got %b expected %b (oidi pipo adak busy pr)", t, $time, got, e);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        checkOutput({outerDoor, innerDoor, pumpIn, pumpOut, arriveAck, departAck, busy, pressurized});
    end

    // One clock cycle: drive inputs, record what the outputs must be during it.
    task automatic applyStimulus(input logic [7:0] expv, input bit care, input string tag,
                                 input bit dc, input bit rst);
        reset     = rst;
        doorClose = dc;
        expQ.push_back(expv);
        careQ.push_back(care);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        doorClose = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic doReset(input bit care, input logic [7:0] firstExp, input bit dc);
        applyStimulus(firstExp, care, "reset_cycle", dc, 1'b1);
        applyStimulus(8'h00, 1'b1, "reset_quiet", rndBit(3), 1'b0);
        for (int i = 0; i < PRESS_N; i++) begin
            applyStimulus(E_PIN | ((i == PRESS_N - 1) ? E_PRESS : 8'h00), 1'b1, "recover", rndBit(4), 1'b0);
        end
        interior = 1'b1;
        lastArr  = 1'b0;
    endtask

    task automatic pumpPhase(input bit isIn, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(E_BUSY | (isIn ? E_PIN : E_POUT) | ((isIn && i == n - 1) ? E_PRESS : 8'h00),
                          1'b1, isIn ? "press" : "evac", rndBit(4), 1'b0);
        end
    endtask

    // k is the cycle of the open period in which DoorClose is pulsed.
    task automatic doorPhase(input bit isOuter, input int k);
        int         openCycles;
        logic [7:0] v;
        openCycles = k;
`ifdef DOOR_TIMEOUT_EN
        if (k > DOOR_N) openCycles = DOOR_N;
`endif
        v = isOuter ? (E_OUTER | E_BUSY) : (E_INNER | E_BUSY | E_PRESS);
        for (int i = 1; i <= openCycles; i++) begin
            if (i == 1) begin
                if (!arriveReq && rndBit(4)) arriveReq = 1'b1;
                if (!departReq && rndBit(4)) departReq = 1'b1;
            end
            if (resetPending && isOuter && i == 2) begin
                resetPending = 1'b0;
                aborted      = 1'b1;
                doReset(1'b1, v, 1'b1);
                return;
            end
            applyStimulus(v, 1'b1, isOuter ? "outer_open" : "inner_open", i == k, 1'b0);
        end
    endtask

    task automatic runOne(input bit longHold);
        int pat;
        bit isArr;
        repeat ($urandom_range(0, 2)) begin
            if (!arriveReq && !departReq) applyStimulus(idleVec(), 1'b1, "idle", rndBit(3), 1'b0);
        end
        if (!arriveReq && !departReq) begin
            pat       = $urandom_range(1, 3);
            arriveReq = pat[0];
            departReq = pat[1];
        end
        isArr = arriveReq && (!departReq || !lastArr);
        applyStimulus(idleVec() | (isArr ? E_AACK : E_DACK), 1'b1, "grant", rndBit(3), 1'b0);
        lastArr = isArr;
        if (!rndBit(4)) begin
            if (isArr) arriveReq = 1'b0;
            else       departReq = 1'b0;
        end
        aborted = 1'b0;
        if (isArr) begin
            if (interior) pumpPhase(1'b0, EVAC_N);
            doorPhase(1'b1, longHold ? 120 : $urandom_range(1, 6));
            if (!aborted) pumpPhase(1'b1, PRESS_N);
            if (!aborted) doorPhase(1'b0, $urandom_range(1, 6));
            if (!aborted) interior = 1'b1;
        end else begin
            if (!interior) pumpPhase(1'b1, PRESS_N);
            doorPhase(1'b0, $urandom_range(1, 6));
            pumpPhase(1'b0, EVAC_N);
            doorPhase(1'b1, longHold ? 120 : $urandom_range(1, 6));
            if (!aborted) interior = 1'b0;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        doReset(1'b0, 8'h00, 1'b0);
        $display("[TB] reset recovery done, starting transits");

        arriveReq = 1'b1;
        runOne(1'b0);

        arriveReq = 1'b1;
        departReq = 1'b1;
        runOne(1'b0);
        runOne(1'b0);

        for (int t = 0; t < 30; t++) begin
            if (t == 4) resetPending = 1'b1;
            runOne(t == 10);
        end

        repeat (2) @(negedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
